// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and default widths for the pipeline stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    localparam int DEFAULT_DATA_W = 64;
    localparam int DEFAULT_CNT_W  = 16;

endpackage
`default_nettype wire

// File: rtl/pipe_stage_skid_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at its all-ones value instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (inc_i && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt_o = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline register with optional 2-entry skid buffer,
//               flush, and saturating stall/flush statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0] FLUSH_VAL = {DATA_W{1'b0}},
    parameter int                SKID      = 1,
    parameter int                CNT_W     = DEFAULT_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    skid_state_t       r_state;
    skid_state_t       w_next_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] w_skid_data;
    logic              w_in_ready;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_load_main_in;
    logic              w_load_main_skid;
    logic              w_load_skid;

    assign out_valid_o = (r_state != EMPTY);
    assign out_data_o  = r_main;
    assign in_ready_o  = w_in_ready;
    assign w_in_fire   = in_valid_i & w_in_ready;
    assign w_out_fire  = out_valid_o & out_ready_i;

    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    w_next_state   = ONE;
                end
            end
            ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid  = 1'b1;
                    w_next_state = TWO;
                end else if (w_out_fire) begin
                    w_next_state = EMPTY;
                end
            end
            TWO: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    w_next_state     = ONE;
                end
            end
            default: w_next_state = EMPTY;
        endcase
        // Flush overrides any transfer decided above; a same-cycle out_fire is still delivered.
        if (flush_i) begin
            w_next_state = EMPTY;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= EMPTY;
            r_main  <= FLUSH_VAL;
        end else begin
            r_state <= w_next_state;
            if (w_load_main_in) begin
                r_main <= in_data_i;
            end else if (w_load_main_skid) begin
                r_main <= w_skid_data;
            end
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] r_skid;
            logic              r_in_ready;

            always_ff @(posedge clk_i) begin
                if (rst_i || flush_i) begin
                    r_skid <= FLUSH_VAL;
                end else if (w_load_skid) begin
                    r_skid <= in_data_i;
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_next_state != TWO);
                end
            end

            assign w_skid_data = r_skid;
            assign w_in_ready  = r_in_ready;
        end else begin : g_no_skid
            assign w_skid_data = FLUSH_VAL;
            assign w_in_ready  = ~out_valid_o | out_ready_i;
        end
    endgenerate

    // Both conditions use the registered valid, i.e. the state before any flush lands.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (out_valid_o & ~out_ready_i),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (flush_i & out_valid_o),
        .cnt_o (flush_cnt_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Directed vector bench for pipe_stage_skid (SKID=1 and SKID=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       a_in_valid = 1'b0;
    logic       a_in_ready;
    logic [7:0] a_in_data = 8'h00;
    logic       a_flush = 1'b0;
    logic       a_out_valid;
    logic       a_out_ready = 1'b0;
    logic [7:0] a_out_data;
    logic [7:0] a_stall_cnt;
    logic [7:0] a_flush_cnt;

    logic       b_in_valid = 1'b0;
    logic       b_in_ready;
    logic [7:0] b_in_data = 8'h00;
    logic       b_flush = 1'b0;
    logic       b_out_valid;
    logic       b_out_ready = 1'b0;
    logic [7:0] b_out_data;
    logic [1:0] b_stall_cnt;
    logic [1:0] b_flush_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_skid #(.DATA_W(8), .FLUSH_VAL(8'hEE), .SKID(1), .CNT_W(8)) u_a (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_data),
        .flush_i(a_flush),
        .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_data),
        .stall_cnt_o(a_stall_cnt), .flush_cnt_o(a_flush_cnt)
    );

    pipe_stage_skid #(.DATA_W(8), .FLUSH_VAL(8'h00), .SKID(0), .CNT_W(2)) u_b (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .in_data_i(b_in_data),
        .flush_i(b_flush),
        .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .out_data_o(b_out_data),
        .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
    );

    typedef struct {
        logic       in_valid;
        logic [7:0] in_data;
        logic       out_ready;
        logic       flush;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_ready;
        logic [7:0] exp_stall;
        logic [7:0] exp_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic [7:0] d, input logic r, input logic f,
                       input logic ev, input logic [7:0] ed, input logic er,
                       input logic [7:0] es, input logic [7:0] ef);
        vec_t t;
        t.in_valid = v; t.in_data = d; t.out_ready = r; t.flush = f;
        t.exp_valid = ev; t.exp_data = ed; t.exp_ready = er;
        t.exp_stall = es; t.exp_flush = ef;
        vecs.push_back(t);
    endtask

    initial begin
        //   v  data   rdy flush | valid data  ready stall flush
        add(1, 8'h0A, 1, 0,      1, 8'h0A, 1,    0,    0);
        for (int k = 1; k <= 8; k++) begin
            add(1, 8'(k), 1, 0,  1, 8'(k), 1,    0,    0);
        end
        add(0, 8'h00, 1, 0,      0, 8'h08, 1,    0,    0);
        // Backpressure into the skid entry, then drain.
        add(1, 8'h01, 0, 0,      1, 8'h01, 1,    0,    0);
        add(1, 8'h02, 0, 0,      1, 8'h01, 0,    1,    0);
        add(0, 8'h00, 0, 0,      1, 8'h01, 0,    2,    0);
        add(0, 8'h00, 1, 0,      1, 8'h02, 1,    2,    0);
        add(0, 8'h00, 1, 0,      0, 8'h02, 1,    2,    0);
        // Fill with 3/4, then flush while 5 is offered.
        add(1, 8'h03, 0, 0,      1, 8'h03, 1,    2,    0);
        add(1, 8'h04, 0, 0,      1, 8'h03, 0,    3,    0);
        add(1, 8'h05, 0, 1,      0, 8'hEE, 1,    4,    1);
        add(0, 8'h00, 1, 0,      0, 8'hEE, 1,    4,    1);
        add(0, 8'h00, 1, 0,      0, 8'hEE, 1,    4,    1);
        add(1, 8'h06, 0, 0,      1, 8'h06, 1,    4,    1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("a_reset_valid", 32'(a_out_valid), 32'd0);
        chk("a_reset_data",  32'(a_out_data),  32'hEE);
        chk("a_reset_ready", 32'(a_in_ready),  32'd1);
        chk("a_reset_stall", 32'(a_stall_cnt), 32'd0);
        chk("b_reset_ready", 32'(b_in_ready),  32'd1);

        foreach (vecs[i]) begin
            a_in_valid  = vecs[i].in_valid;
            a_in_data   = vecs[i].in_data;
            a_out_ready = vecs[i].out_ready;
            a_flush     = vecs[i].flush;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_valid", i), 32'(a_out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), 32'(a_out_data), 32'(vecs[i].exp_data));
            else if (vecs[i].exp_data == 8'hEE)
                chk($sformatf("vec%0d_flushdata", i), 32'(a_out_data), 32'hEE);
            chk($sformatf("vec%0d_ready", i), 32'(a_in_ready), 32'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_stall", i), 32'(a_stall_cnt), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_flushcnt", i), 32'(a_flush_cnt), 32'(vecs[i].exp_flush));
        end

        // Reset together with flush while holding a beat.
        a_in_valid = 1'b0;
        a_flush    = 1'b1;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        a_flush = 1'b0;
        chk("rst_flush_valid", 32'(a_out_valid), 32'd0);
        chk("rst_flush_data",  32'(a_out_data),  32'hEE);
        chk("rst_flush_ready", 32'(a_in_ready),  32'd1);
        chk("rst_flush_stall", 32'(a_stall_cnt), 32'd0);
        chk("rst_flush_fcnt",  32'(a_flush_cnt), 32'd0);

        // SKID=0: combinational ready and a 2-bit saturating stall counter.
        b_in_valid  = 1'b1;
        b_in_data   = 8'h07;
        b_out_ready = 1'b0;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("b_load_valid", 32'(b_out_valid), 32'd1);
        chk("b_load_data",  32'(b_out_data),  32'h07);
        chk("b_ready_low",  32'(b_in_ready),  32'd0);
        repeat (6) @(posedge clk);
        #1;
        chk("b_stall_sat",  32'(b_stall_cnt), 32'd3);
        chk("b_hold_data",  32'(b_out_data),  32'h07);
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'h09;
        #1;
        chk("b_ready_comb", 32'(b_in_ready),  32'd1);
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        chk("b_new_valid",  32'(b_out_valid), 32'd1);
        chk("b_new_data",   32'(b_out_data),  32'h09);
        chk("b_stall_hold", 32'(b_stall_cnt), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register; next-generation replacement for the fixed 32+32-bit IF/ID-style register.
- Adds a valid/ready handshake, an optional 2-entry skid buffer so `in_ready_o` is registered, configurable payload width and flush value, and saturating stall/flush statistics counters.
- Sits between any two CPU pipeline stages (IF/ID, ID/EX, ...); the hazard unit drives `flush_i`, and backpressure replaces the old stall input.

Parameters:
- DATA_W, 64, payload width in bits (e.g. {pc, inst}).
- FLUSH_VAL, {DATA_W{1'b0}}, value loaded into both data registers on reset/flush.
- SKID, 1, 1 = 2-entry skid buffer with registered `in_ready_o`; 0 = single entry, combinational `in_ready_o`.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- in_valid_i  in  1  upstream payload valid.
- in_ready_o  out  1  block can accept a beat this cycle.
- in_data_i  in  DATA_W  upstream payload.
- flush_i  in  1  discard all held and incoming beats.
- out_valid_o  out  1  `out_data_o` is valid.
- out_ready_i  in  1  downstream accepts this cycle.
- out_data_o  out  DATA_W  payload to the next stage (always the main register).
- stall_cnt_o  out  CNT_W  cycles with out_valid_o=1 and out_ready_i=0.
- flush_cnt_o  out  CNT_W  cycles with flush_i=1 and out_valid_o=1.

Behaviour:
- Handshakes:
  - in_fire = in_valid_i & in_ready_o.
  - out_fire = out_valid_o & out_ready_i.
  - Data transfers only on a fire.
  - Upstream must hold in_data_i stable while in_valid_i=1 and in_ready_o=0.
- State, SKID=1: EMPTY (no entry), ONE (main full), TWO (main + skid full).
  - out_valid_o = (state != EMPTY).
  - in_ready_o = registered (next_state != TWO).
- Transitions and data moves, SKID=1:
  - EMPTY, in_fire: main <= in_data_i; go to ONE.
  - ONE, in_fire & out_fire: main <= in_data_i; stay in ONE.
  - ONE, in_fire only: skid <= in_data_i; go to TWO.
  - ONE, out_fire only: go to EMPTY; main data is held, not cleared.
  - TWO, out_fire: main <= skid; go to ONE. in_ready_o is 0 in TWO, so no input is taken.
  - Any other case: hold.
- Throughput and latency:
  - Latency is 1 cycle: a beat taken at edge N appears on out_data_o after edge N.
  - Sustains 1 beat/cycle with out_ready_i held high.
  - Order is strictly FIFO; no beat is dropped or duplicated.
- SKID=0:
  - Single entry; state TWO is unreachable.
  - in_ready_o = ~out_valid_o | out_ready_i (combinational).
  - Skid register is not implemented.
- Flush (priority over everything except reset):
  - Both data registers <= FLUSH_VAL; state <= EMPTY; out_valid_o=0 on the next cycle.
  - An in_fire in the same cycle is discarded. The hazard unit flushes upstream in the same cycle.
  - An out_fire in the same cycle still counts as delivered downstream.
- Reset (rst_i=1 at an edge, including mid-transfer):
  - State EMPTY; data = FLUSH_VAL; out_valid_o=0.
  - in_ready_o=1 after the edge for SKID=1; it follows its equation for SKID=0.
  - Both counters = 0.
  - Reset has priority over flush.
- Counters:
  - Each increments by 1 per qualifying cycle and saturates at 2^CNT_W-1 (no wrap).
  - Neither is updated in a reset cycle.
  - The stall condition is sampled before that cycle's flush takes effect.

Decomposition:
- Shared package `pipe_pkg`: typedef `skid_state_t` {EMPTY=2'd0, ONE=2'd1, TWO=2'd2}; localparam defaults for DATA_W and CNT_W.
- One sub-module, `sat_counter` (params W; ports clk_i, rst_i, inc_i, cnt_o), instantiated twice.

Test Plan:
- Reset, then in_valid_i=1, data=0xA, out_ready_i=1 -> next cycle out_valid_o=1, out_data_o=0xA; stall_cnt_o=0.
- Stream 0x1..0x8 with out_ready_i=1 -> 8 consecutive output beats in order, in_ready_o constantly 1, 1-cycle latency.
- SKID=1: out_ready_i=0 while sending 0x1, 0x2 -> state TWO, in_ready_o=0, out_data_o=0x1, stall_cnt_o increments each cycle. Then out_ready_i=1 -> 0x1 then 0x2 delivered, in_ready_o returns to 1 after the first drain.
- From TWO holding 0x3/0x4, assert flush_i together with in_valid_i (data 0x5) -> next cycle out_valid_o=0, out_data_o=FLUSH_VAL, 0x5 never appears, flush_cnt_o=1.
- Assert rst_i while in ONE with flush_i=1 -> EMPTY, counters 0, out_data_o=FLUSH_VAL. With CNT_W=2, hold stall for 6 cycles -> stall_cnt_o saturates at 3.
- SKID=0: out_ready_i=0 with out_valid_o=1 -> in_ready_o=0 in the same cycle. Raise out_ready_i with new data 0x9 -> in_ready_o=1 that cycle, 0x9 on the output next cycle.
